// File: rtl/boot_fetch_unit.sv
// boot_fetch_unit: boot-loader sequencer merged with instruction fetch and
// the IF/ID pipeline register.
//
// After reset the unit copies BOOT_WORDS words from a valid/ready BIOS stream
// into instruction memory at BOOT_BASE onwards. It then hands the single
// memory port over to instruction fetch, which handles PC, PC+1, branch
// redirect, stall and flush.
//
// Ports:
//   clock, reset                    system clock, async active-high reset
//   boot_valid, boot_data           BIOS stream in
//   boot_ready                      BIOS word accepted this cycle
//   mem_cs/we/oe/address/wdata      memory port out
//   mem_rdata                       memory read data (combinational from address)
//   stall, branch_taken, branch_target   pipeline control
//   on_bios, boot_done              phase indicators
//   pc, pcpp, instruction, instr_valid   fetch address and IF/ID register
//
// state | meaning
// BOOT  | accepting BIOS words and writing them to memory
// FETCH | fetching instructions; terminal until reset
module boot_fetch_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BOOT_WORDS = 16,
    parameter logic [ADDR_WIDTH-1:0] BOOT_BASE    = '0,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  boot_valid,
    input  logic [DATA_WIDTH-1:0] boot_data,
    output logic                  boot_ready,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  on_bios,
    output logic                  boot_done,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pcpp,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  instr_valid
);

    // Width is kept at least 1 so BOOT_WORDS==0 still elaborates.
    localparam int CW = (BOOT_WORDS > 0) ? $clog2(BOOT_WORDS + 1) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(BOOT_WORDS - 1);

    typedef enum logic {
        BOOT  = 1'b0,
        FETCH = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (BOOT_WORDS == 0) ? FETCH : BOOT;

    state_t                state, state_next;
    logic [CW-1:0]         counter, counter_next;
    logic [ADDR_WIDTH-1:0] pc_next, pcpp_next;
    logic [DATA_WIDTH-1:0] instruction_next;
    logic                  instr_valid_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= RESET_STATE;
            counter     <= '0;
            pc          <= RESET_VECTOR;
            pcpp        <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_next;
            counter     <= counter_next;
            pc          <= pc_next;
            pcpp        <= pcpp_next;
            instruction <= instruction_next;
            instr_valid <= instr_valid_next;
        end
    end

    always_comb begin
        state_next       = state;
        counter_next     = counter;
        pc_next          = pc;
        pcpp_next        = pcpp;
        instruction_next = instruction;
        instr_valid_next = instr_valid;
        boot_ready       = 1'b0;
        mem_cs           = 1'b1;
        mem_we           = 1'b0;
        mem_oe           = 1'b0;
        mem_address      = pc;
        mem_wdata        = '0;

        case (state)
            BOOT: begin
                boot_ready  = 1'b1;
                mem_we      = boot_valid;
                mem_address = BOOT_BASE + ADDR_WIDTH'(counter);
                mem_wdata   = boot_data;
                // boot_ready is always high here, so valid alone is the handshake.
                if (boot_valid) begin
                    counter_next = counter + CW'(1);
                    if (counter == LAST_WORD) begin
                        state_next = FETCH;
                        pc_next    = RESET_VECTOR;
                    end
                end
            end
            FETCH: begin
                mem_oe = 1'b1;
                if (branch_taken) begin
                    // Redirect wins over stall; the instruction in IF/ID is squashed.
                    pc_next          = branch_target;
                    instr_valid_next = 1'b0;
                end else if (!stall) begin
                    pc_next          = pc + ADDR_WIDTH'(1);
                    pcpp_next        = pc + ADDR_WIDTH'(1);
                    instruction_next = mem_rdata;
                    instr_valid_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign on_bios   = (state == BOOT);
    assign boot_done = (state == FETCH);

endmodule
